// File: rtl/rf_host_arbiter_if.sv
// Register-file sharing bus: pipeline writeback/decode side,
// reg_data side and host debug/loader side of rf_host_arbiter.
interface rf_host_arbiter_if;
    logic [3:0]  w_dstE;
    logic [63:0] w_valE;
    logic [3:0]  w_dstM;
    logic [63:0] w_valM;
    logic [3:0]  d_srcA;
    logic [63:0] d_valA;
    logic [3:0]  rf_dstE;
    logic [63:0] rf_valE;
    logic [3:0]  rf_dstM;
    logic [63:0] rf_valM;
    logic [3:0]  rf_srcA;
    logic [63:0] rf_valA;
    logic        pipe_hold;
    logic        host_req;
    logic [1:0]  host_op;
    logic [3:0]  host_reg;
    logic [63:0] host_wdata;
    logic        host_ack;
    logic        host_err;
    logic        host_rvalid;
    logic [3:0]  host_ridx;
    logic [63:0] host_rdata;
    logic        host_busy;

    modport master (
        output w_dstE, w_valE, w_dstM, w_valM, d_srcA,
        output rf_valA,
        output host_req, host_op, host_reg, host_wdata,
        input  d_valA, rf_dstE, rf_valE, rf_dstM, rf_valM,
        input  rf_srcA, pipe_hold,
        input  host_ack, host_err, host_rvalid,
        input  host_ridx, host_rdata, host_busy
    );

    modport slave (
        input  w_dstE, w_valE, w_dstM, w_valM, d_srcA,
        input  rf_valA,
        input  host_req, host_op, host_reg, host_wdata,
        output d_valA, rf_dstE, rf_valE, rf_dstM, rf_valM,
        output rf_srcA, pipe_hold,
        output host_ack, host_err, host_rvalid,
        output host_ridx, host_rdata, host_busy
    );
endinterface

// File: rtl/rf_host_arbiter.sv
// Shares the reg_data ports between pipeline writeback and a host
// debug/loader port (single write, single read, full dump).
module rf_host_arbiter #(
    parameter int NREGS        = 15,
    parameter int DRAIN_CYCLES = 4
) (
    input logic              clock,
    input logic              resetn,
    rf_host_arbiter_if.slave bus
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [3:0] NONE = 4'hF;
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_EXEC,
        S_DUMP,
        S_ACK
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [3:0]     reg_q, reg_d;
    logic [63:0]    wdata_q, wdata_d;
    logic           err_q, err_d;
    logic           hold_q, hold_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic           rvalid_q, rvalid_d;
    logic [3:0]     ridx_q, ridx_d;
    logic [63:0]    rdata_q, rdata_d;
    logic           bad_req;
    logic           own;
    logic [3:0]     dstE, dstM, srcA;
    logic [63:0]    valE;

    assign bad_req = (bus.host_op == OP_RSVD) ||
                     (bus.host_op != OP_DUMP && bus.host_reg == NONE);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rvalid_d = 1'b0;
        ridx_d   = ridx_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.host_req) begin
                    op_d    = bus.host_op;
                    reg_d   = bus.host_reg;
                    wdata_d = bus.host_wdata;
                    err_d   = bad_req;
                    cnt_d   = '0;
                    state_d = bad_req ? S_ACK : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                    idx_d   = '0;
                    state_d = (op_q == OP_DUMP) ? S_DUMP : S_EXEC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXEC: begin
                if (op_q == OP_READ) begin
                    rvalid_d = 1'b1;
                    ridx_d   = reg_q;
                    rdata_d  = bus.rf_valA;
                end
                state_d = S_ACK;
            end
            S_DUMP: begin
                rvalid_d = 1'b1;
                ridx_d   = idx_q;
                rdata_d  = bus.rf_valA;
                if (idx_q == 4'(NREGS - 1)) begin
                    state_d = S_ACK;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Rejected requests ack without ever stalling the pipeline.
    assign hold_d = (state_d == S_DRAIN) || (state_d == S_EXEC) ||
                    (state_d == S_DUMP) ||
                    (state_d == S_ACK && !err_d);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= OP_WRITE;
            reg_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            rvalid_q <= 1'b0;
            ridx_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rvalid_q <= rvalid_d;
            ridx_q   <= ridx_d;
            rdata_q  <= rdata_d;
        end
    end

    // Host owns the ports only after the drain, and only for held ops.
    assign own = hold_q && (state_q != S_DRAIN);

    always_comb begin
        dstE = bus.w_dstE;
        dstM = bus.w_dstM;
        valE = bus.w_valE;
        srcA = bus.d_srcA;
        if (own) begin
            dstE = NONE;
            dstM = NONE;
            if (state_q == S_EXEC && op_q == OP_WRITE) begin
                dstE = reg_q;
                valE = wdata_q;
            end
            if (state_q == S_EXEC && op_q == OP_READ) begin
                srcA = reg_q;
            end
            if (state_q == S_DUMP) begin
                srcA = idx_q;
            end
        end
        if (!resetn) begin
            dstE = NONE;
            dstM = NONE;
        end
    end

    assign bus.rf_dstE     = dstE;
    assign bus.rf_valE     = valE;
    assign bus.rf_dstM     = dstM;
    assign bus.rf_valM     = bus.w_valM;
    assign bus.rf_srcA     = srcA;
    assign bus.d_valA      = bus.rf_valA;
    assign bus.pipe_hold   = hold_q;
    assign bus.host_ack    = (state_q == S_ACK);
    assign bus.host_err    = (state_q == S_ACK) && err_q;
    assign bus.host_busy   = (state_q != S_IDLE);
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_ridx   = ridx_q;
    assign bus.host_rdata  = rdata_q;
endmodule

// File: tb/tb_rf_host_arbiter.sv
// Self-checking bench for rf_host_arbiter with a behavioural
// register file and a per-register model of its expected contents.
module tb_rf_host_arbiter;
    localparam int NR = 15;
    localparam int DR = 4;
    localparam logic [3:0] NONE = 4'hF;
    localparam logic [1:0] OP_W = 2'b00;
    localparam logic [1:0] OP_R = 2'b01;
    localparam logic [1:0] OP_D = 2'b10;
    localparam logic [1:0] OP_X = 2'b11;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    rf_host_arbiter_if bus();

    rf_host_arbiter #(.NREGS(NR), .DRAIN_CYCLES(DR)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    logic [63:0] rf [16];
    always @(posedge clock) begin
        if (bus.rf_dstE != NONE) rf[bus.rf_dstE] <= bus.rf_valE;
        if (bus.rf_dstM != NONE) rf[bus.rf_dstM] <= bus.rf_valM;
    end
    assign bus.rf_valA = (bus.rf_srcA == NONE) ? 64'd0 : rf[bus.rf_srcA];

    logic [63:0] mdl [16];
    int checks = 0;
    int errors = 0;

    int          r_lat, r_hold;
    logic        r_err;
    logic [3:0]  r_ridx [$];
    logic [63:0] r_rdata [$];
    int          r_rvn [$];

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  rg;
        logic [63:0] wd;
        int          wb_cyc;
        logic [3:0]  wb_reg;
        logic [63:0] wb_val;
        logic        e_err;
        int          e_lat;
        int          e_hold;
        int          e_rv;
    } vec_t;
    vec_t vt [$];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_rf(input string nm);
        int bad;
        bad = -1;
        for (int i = 0; i < NR; i++)
            if (rf[i] !== mdl[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: reg %0d got %h expected %h",
                     nm, bad, rf[bad], mdl[bad]);
        end
    endtask

    function automatic logic exp_err(input logic [1:0] op,
                                     input logic [3:0] rg);
        return (op == OP_X) || (op != OP_D && rg == NONE);
    endfunction

    function automatic int exp_lat(input logic [1:0] op,
                                   input logic [3:0] rg);
        if (exp_err(op, rg)) return 1;
        if (op == OP_D) return DR + NR + 1;
        return DR + 2;
    endfunction

    function automatic int exp_rv(input logic [1:0] op,
                                  input logic [3:0] rg);
        if (exp_err(op, rg)) return 0;
        if (op == OP_D) return NR;
        if (op == OP_R) return 1;
        return 0;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [3:0] rg,
                          input logic [63:0] wd, input int wb_cyc,
                          input logic [3:0] wb_reg,
                          input logic [63:0] wb_val);
        int n;
        bit done;
        r_hold = 0;
        r_err = 1'b0;
        r_ridx.delete();
        r_rdata.delete();
        r_rvn.delete();
        @(posedge clock); #1;
        bus.host_req = 1'b1;
        bus.host_op = op;
        bus.host_reg = rg;
        bus.host_wdata = wd;
        n = 0;
        done = 0;
        while (!done && n < 200) begin
            @(posedge clock); #1;
            bus.host_req = 1'b0;
            n++;
            if (n == wb_cyc) begin
                bus.w_dstE = wb_reg;
                bus.w_valE = wb_val;
                mdl[wb_reg] = wb_val;
            end else begin
                bus.w_dstE = NONE;
            end
            @(negedge clock);
            if (bus.pipe_hold) r_hold++;
            if (bus.host_rvalid) begin
                r_ridx.push_back(bus.host_ridx);
                r_rdata.push_back(bus.host_rdata);
                r_rvn.push_back(n);
            end
            if (bus.host_ack) begin
                done = 1;
                r_err = bus.host_err;
            end
        end
        r_lat = n;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: no ack after %0d cycles", n);
        end
        @(posedge clock); #1;
        bus.w_dstE = NONE;
        @(negedge clock);
        chk("hold_after_ack", 64'(bus.pipe_hold), 64'd0);
    endtask

    task automatic check_op(input string nm, input logic [1:0] op,
                            input logic [3:0] rg, input logic [63:0] wd,
                            input logic e_err, input int e_lat,
                            input int e_hold, input int e_rv);
        chk({nm, ".err"}, 64'(r_err), 64'(e_err));
        chk({nm, ".lat"}, 64'(r_lat), 64'(e_lat));
        chk({nm, ".hold"}, 64'(r_hold), 64'(e_hold));
        chk({nm, ".nrv"}, 64'(r_ridx.size()), 64'(e_rv));
        for (int k = 0; k < r_ridx.size() && k < NR; k++) begin
            if (op == OP_D) begin
                chk($sformatf("%s.ridx%0d", nm, k), 64'(r_ridx[k]), 64'(k));
                chk($sformatf("%s.rd%0d", nm, k), r_rdata[k], mdl[k]);
                chk($sformatf("%s.pos%0d", nm, k), 64'(r_rvn[k]),
                    64'(DR + 2 + k));
            end else begin
                chk({nm, ".ridx"}, 64'(r_ridx[k]), 64'(rg));
                chk({nm, ".rdata"}, r_rdata[k], mdl[rg]);
            end
        end
        if (!e_err && op == OP_W) mdl[rg] = wd;
        chk_rf({nm, ".rf"});
    endtask

    initial begin
        logic [13:0] hv, av;
        int n;
        bit seen;
        bus.host_req = 1'b0;
        bus.host_op = OP_W;
        bus.host_reg = 4'd0;
        bus.host_wdata = 64'd0;
        bus.w_dstE = 4'd3;
        bus.w_valE = 64'd0;
        bus.w_dstM = 4'd4;
        bus.w_valM = 64'd0;
        bus.d_srcA = 4'd0;
        #1;
        chk("rst.hold", 64'(bus.pipe_hold), 64'd0);
        chk("rst.ack", 64'(bus.host_ack), 64'd0);
        chk("rst.err", 64'(bus.host_err), 64'd0);
        chk("rst.rvalid", 64'(bus.host_rvalid), 64'd0);
        chk("rst.busy", 64'(bus.host_busy), 64'd0);
        chk("rst.rdata", bus.host_rdata, 64'd0);
        chk("rst.ridx", 64'(bus.host_ridx), 64'd0);
        chk("rst.dstE", 64'(bus.rf_dstE), 64'(NONE));
        chk("rst.dstM", 64'(bus.rf_dstM), 64'(NONE));
        bus.w_dstE = NONE;
        bus.w_dstM = NONE;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // preload reg i = 0x100+i through the idle pass-through path
        for (int i = 0; i < NR; i++) begin
            @(posedge clock); #1;
            bus.w_dstE = NONE;
            bus.w_dstM = NONE;
            if (i % 2 == 0) begin
                bus.w_dstE = 4'(i);
                bus.w_valE = 64'h100 + 64'(i);
            end else begin
                bus.w_dstM = 4'(i);
                bus.w_valM = 64'h100 + 64'(i);
            end
            mdl[i] = 64'h100 + 64'(i);
            @(negedge clock);
            if (i % 2 == 0) begin
                chk("pass.dstE", 64'(bus.rf_dstE), 64'(i));
                chk("pass.valE", bus.rf_valE, 64'h100 + 64'(i));
            end else begin
                chk("pass.dstM", 64'(bus.rf_dstM), 64'(i));
                chk("pass.valM", bus.rf_valM, 64'h100 + 64'(i));
            end
        end
        @(posedge clock); #1;
        bus.w_dstE = NONE;
        bus.w_dstM = NONE;
        bus.d_srcA = 4'd5;
        #1;
        chk("pass.valA", bus.d_valA, 64'h105);
        chk_rf("preload");

        vt.push_back('{OP_D, 4'd0, 64'd0, 0, 4'd0, 64'd0,
                       1'b0, 20, 20, 15});
        vt.push_back('{OP_W, 4'd3, 64'h1122334455667788, 0, 4'd0, 64'd0,
                       1'b0, 6, 6, 0});
        vt.push_back('{OP_R, 4'd0, 64'd0, 2, 4'd0, 64'd5,
                       1'b0, 6, 6, 1});
        vt.push_back('{OP_X, 4'd2, 64'hDEAD, 0, 4'd0, 64'd0,
                       1'b1, 1, 0, 0});
        vt.push_back('{OP_W, 4'hF, 64'hBEEF, 0, 4'd0, 64'd0,
                       1'b1, 1, 0, 0});
        vt.push_back('{OP_R, 4'hF, 64'd0, 0, 4'd0, 64'd0,
                       1'b1, 1, 0, 0});
        vt.push_back('{OP_R, 4'd3, 64'd0, 0, 4'd0, 64'd0,
                       1'b0, 6, 6, 1});
        vt.push_back('{OP_D, 4'd0, 64'd0, 3, 4'd9, 64'hDEAD_0009,
                       1'b0, 20, 20, 15});
        vt.push_back('{OP_W, 4'd14, 64'hABCD, 1, 4'd14, 64'h7,
                       1'b0, 6, 6, 0});
        for (int v = 0; v < vt.size(); v++) begin
            run_op(vt[v].op, vt[v].rg, vt[v].wd,
                   vt[v].wb_cyc, vt[v].wb_reg, vt[v].wb_val);
            check_op($sformatf("vec%0d", v), vt[v].op, vt[v].rg,
                     vt[v].wd, vt[v].e_err, vt[v].e_lat,
                     vt[v].e_hold, vt[v].e_rv);
        end
        chk("rbx", rf[3], 64'h1122334455667788);
        chk("rax", rf[0], 64'd5);

        // reset in the middle of a dump
        @(posedge clock); #1;
        bus.host_req = 1'b1;
        bus.host_op = OP_D;
        @(posedge clock); #1;
        bus.host_req = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clock);
            n++;
            if (bus.host_rvalid && bus.host_ridx == 4'd6) seen = 1;
        end
        chk("rst_mid.seen", 64'(seen), 64'd1);
        bus.w_dstE = 4'd2;
        bus.w_valE = 64'hBAD;
        bus.w_dstM = 4'd4;
        bus.w_valM = 64'hBAD;
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid.hold", 64'(bus.pipe_hold), 64'd0);
        chk("rst_mid.ack", 64'(bus.host_ack), 64'd0);
        chk("rst_mid.rvalid", 64'(bus.host_rvalid), 64'd0);
        chk("rst_mid.busy", 64'(bus.host_busy), 64'd0);
        chk("rst_mid.rdata", bus.host_rdata, 64'd0);
        chk("rst_mid.ridx", 64'(bus.host_ridx), 64'd0);
        chk("rst_mid.dstE", 64'(bus.rf_dstE), 64'(NONE));
        chk("rst_mid.dstM", 64'(bus.rf_dstM), 64'(NONE));
        @(posedge clock);
        @(negedge clock);
        bus.w_dstE = NONE;
        bus.w_dstM = NONE;
        #1 resetn = 1'b1;
        run_op(OP_R, 4'd5, 64'd0, 0, 4'd0, 64'd0);
        check_op("rst_read", OP_R, 4'd5, 64'd0, 1'b0, 6, 6, 1);

        // host_req held across two writes
        @(posedge clock); #1;
        bus.host_req = 1'b1;
        bus.host_op = OP_W;
        bus.host_reg = 4'd7;
        bus.host_wdata = 64'hAAAA_0001;
        hv = '0;
        av = '0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clock); #1;
            if (c == 1) bus.host_wdata = 64'hBBBB_0002;
            if (c == 8) bus.host_req = 1'b0;
            @(negedge clock);
            hv[c-1] = bus.pipe_hold;
            av[c-1] = bus.host_ack;
        end
        chk("held.hold", 64'(hv), 64'(14'b01111110111111));
        chk("held.ack", 64'(av), 64'(14'b01000000100000));
        mdl[7] = 64'hBBBB_0002;
        chk_rf("held.rf");

        // randomized ops with random drain-time writebacks
        for (int t = 0; t < 30; t++) begin
            logic [1:0]  op;
            logic [3:0]  rg, wr;
            logic [63:0] wd, wv;
            int          wc;
            op = 2'($urandom_range(0, 3));
            rg = 4'($urandom_range(0, 15));
            wd = {$urandom, $urandom};
            wr = 4'($urandom_range(0, NR - 1));
            wv = {$urandom, $urandom};
            wc = exp_err(op, rg) ? 0 : $urandom_range(0, DR);
            run_op(op, rg, wd, wc, wr, wv);
            check_op($sformatf("rnd%0d", t), op, rg, wd,
                     exp_err(op, rg), exp_lat(op, rg),
                     exp_err(op, rg) ? 0 : exp_lat(op, rg),
                     exp_rv(op, rg));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
